// File: rtl/lfsr_pkg.sv
// Shared types and constants for the BIST LFSR pattern generator / signature compactor.
// Holds the run FSM encoding and a maximal-length tap table for state widths 3..16.
package lfsr_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fsm_t;

   localparam logic [7:0] DEF_POLY_W8 = 8'b0001_1101;

   // Tap masks for a right-shifting Fibonacci LFSR (feedback enters the MSB).
   function automatic logic [15:0] max_len_taps(input int width);
      logic [15:0] taps;
      case (width)
         3:       taps = 16'h0003;
         4:       taps = 16'h0003;
         5:       taps = 16'h0005;
         6:       taps = 16'h0003;
         7:       taps = 16'h0003;
         8:       taps = {8'h00, DEF_POLY_W8};
         9:       taps = 16'h0011;
         10:      taps = 16'h0009;
         11:      taps = 16'h0005;
         12:      taps = 16'h0941;
         13:      taps = 16'h1601;
         14:      taps = 16'h2A01;
         15:      taps = 16'h0003;
         16:      taps = 16'h100B;
         default: taps = 16'h0003;
      endcase
      return taps;
   endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational next-state of the Fibonacci LFSR, with optional MISR response folding.
module lfsr_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] state,
   input  logic [WIDTH-1:0] poly,
   input  logic [WIDTH-1:0] din,
   input  logic             misr,
   output logic [WIDTH-1:0] next
);

   logic fb;

   // Feedback parity of the tapped bits, shifted in at the MSB.
   always_comb begin
      fb   = ^(state & poly);
      next = {fb, state[WIDTH-1:1]};
      if (misr) begin
         next = next ^ din;
      end else begin
         next = next;
      end
   end

endmodule

// File: rtl/lfsr_prpg.sv
// BIST LFSR pattern generator / MISR with loadable seed and taps and a counted run.
// A run of N_pat steps is framed by Busy, each step flagged by Valid, the last by Done.
module lfsr_prpg
   import lfsr_pkg::*;
#(
   parameter int              WIDTH    = 8,
   parameter int              CNT_W    = 16,
   parameter logic [WIDTH-1:0] DEF_POLY = WIDTH'(max_len_taps(WIDTH)),
   parameter logic [WIDTH-1:0] DEF_SEED = '1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             Seed_ld,
   input  logic [WIDTH-1:0] Seed_val,
   input  logic             Poly_ld,
   input  logic [WIDTH-1:0] Poly_val,
   input  logic             Mode,
   input  logic             Start,
   input  logic [CNT_W-1:0] N_pat,
   input  logic [WIDTH-1:0] Din,
   output logic [WIDTH-1:0] Q,
   output logic             Valid,
   output logic             Busy,
   output logic             Done,
   output logic             Lockup
);

   fsm_t             fsm;
   fsm_t             fsm_next;
   logic [WIDTH-1:0] poly;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] run_len;
   logic             run_mode;
   logic [WIDTH-1:0] step_next;
   logic             do_step;
   logic             take_start;
   logic             zero_start;
   logic             last_step;

   lfsr_step #(.WIDTH(WIDTH)) u_step (
      .state (Q),
      .poly  (poly),
      .din   (Din),
      .misr  (run_mode),
      .next  (step_next)
   );

   // FSM state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         fsm <= IDLE;
      end else begin
         fsm <= fsm_next;
      end
   end

   // Next-state decode; Seed_ld aborts, Poly_ld outranks Start in IDLE.
   always_comb begin
      fsm_next   = fsm;
      do_step    = 1'b0;
      take_start = 1'b0;
      zero_start = 1'b0;
      last_step  = 1'b0;
      if (Seed_ld) begin
         fsm_next = IDLE;
      end else begin
         case (fsm)
            IDLE: begin
               if (!Poly_ld && Start) begin
                  if (N_pat != {CNT_W{1'b0}}) begin
                     take_start = 1'b1;
                     fsm_next   = RUN;
                  end else begin
                     zero_start = 1'b1;
                  end
               end else begin
                  fsm_next = IDLE;
               end
            end
            RUN: begin
               do_step = 1'b1;
               if (cnt == run_len - CNT_W'(1)) begin
                  last_step = 1'b1;
                  fsm_next  = IDLE;
               end else begin
                  fsm_next = RUN;
               end
            end
            default: begin
               fsm_next = IDLE;
            end
         endcase
      end
   end

   // Datapath registers and registered status flags.
   always_ff @(posedge CLK) begin
      if (RST) begin
         Q        <= DEF_SEED;
         poly     <= DEF_POLY;
         cnt      <= {CNT_W{1'b0}};
         run_len  <= {CNT_W{1'b0}};
         run_mode <= 1'b0;
         Valid    <= 1'b0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
         Lockup   <= 1'b0;
      end else if (Seed_ld) begin
         Q      <= Seed_val;
         cnt    <= {CNT_W{1'b0}};
         Valid  <= 1'b0;
         Busy   <= 1'b0;
         Done   <= 1'b0;
         Lockup <= 1'b0;
      end else begin
         if (fsm == IDLE && Poly_ld) begin
            poly <= Poly_val;
         end
         if (take_start) begin
            run_len  <= N_pat;
            run_mode <= Mode;
            cnt      <= {CNT_W{1'b0}};
         end
         if (do_step) begin
            Q   <= step_next;
            cnt <= last_step ? {CNT_W{1'b0}} : cnt + CNT_W'(1);
         end
         // All-zero is a dead state for PRPG but a legitimate MISR signature.
         if (do_step && !run_mode && step_next == {WIDTH{1'b0}}) begin
            Lockup <= 1'b1;
         end
         Valid <= do_step;
         Done  <= last_step | zero_start;
         Busy  <= (fsm_next == RUN) | do_step;
      end
   end

endmodule

// File: tb/tb_lfsr_prpg.sv
// Directed table-driven bench for lfsr_prpg at WIDTH=4 with hand-computed expectations.
module tb_lfsr_prpg;

   localparam int W = 4;
   localparam int C = 16;

   logic         clk = 1'b0;
   logic         rst, seed_ld, poly_ld, mode, start;
   logic [W-1:0] seed_val, poly_val, din;
   logic [C-1:0] n_pat;
   logic [W-1:0] q;
   logic         valid, busy, done, lockup;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic         rst;
      logic         sld;
      logic [W-1:0] sval;
      logic         pld;
      logic [W-1:0] pval;
      logic         mode;
      logic         start;
      logic [C-1:0] npat;
      logic [W-1:0] din;
      logic [W-1:0] eq;
      logic         evalid;
      logic         ebusy;
      logic         edone;
      logic         elock;
   } vec_t;

   vec_t vecs[$];

   lfsr_prpg #(
      .WIDTH    (W),
      .CNT_W    (C),
      .DEF_POLY (4'b0011),
      .DEF_SEED (4'b1111)
   ) dut (
      .CLK      (clk),
      .RST      (rst),
      .Seed_ld  (seed_ld),
      .Seed_val (seed_val),
      .Poly_ld  (poly_ld),
      .Poly_val (poly_val),
      .Mode     (mode),
      .Start    (start),
      .N_pat    (n_pat),
      .Din      (din),
      .Q        (q),
      .Valid    (valid),
      .Busy     (busy),
      .Done     (done),
      .Lockup   (lockup)
   );

   always #5 clk = ~clk;

   function automatic vec_t v(logic r, logic sl, logic [W-1:0] sv, logic pl, logic [W-1:0] pv,
                              logic m, logic st, logic [C-1:0] np, logic [W-1:0] d,
                              logic [W-1:0] eq, logic ev, logic eb, logic ed, logic el);
      vec_t t;
      t.rst = r; t.sld = sl; t.sval = sv; t.pld = pl; t.pval = pv; t.mode = m;
      t.start = st; t.npat = np; t.din = d; t.eq = eq; t.evalid = ev; t.ebusy = eb;
      t.edone = ed; t.elock = el;
      return t;
   endfunction

   // Idle-input vector: only the expected outputs vary.
   function automatic vec_t idle(logic [W-1:0] eq, logic ev, logic eb, logic ed, logic el);
      return v(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0, 4'b0000, eq, ev, eb, ed, el);
   endfunction

   task automatic apply(input vec_t t, input string name);
      @(negedge clk);
      rst = t.rst; seed_ld = t.sld; seed_val = t.sval; poly_ld = t.pld; poly_val = t.pval;
      mode = t.mode; start = t.start; n_pat = t.npat; din = t.din;
      @(posedge clk);
      #1;
      vectors++;
      if ({q, valid, busy, done, lockup} !== {t.eq, t.evalid, t.ebusy, t.edone, t.elock}) begin
         miscompares++;
         $display("FAIL %s: got Q=%b V=%b B=%b D=%b L=%b, want Q=%b V=%b B=%b D=%b L=%b",
                  name, q, valid, busy, done, lockup,
                  t.eq, t.evalid, t.ebusy, t.edone, t.elock);
      end
   endtask

   logic [W-1:0] seq15 [15];

   initial begin
      rst = 1'b1; seed_ld = 1'b0; poly_ld = 1'b0; mode = 1'b0; start = 1'b0;
      seed_val = '0; poly_val = '0; din = '0; n_pat = '0;

      // Reset, load, 4-step PRPG run
      vecs.push_back(v(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(v(1'b0, 1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0011, 1'b0, 1'b0, 16'd0, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 16'd4, 4'b0000, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0));
      vecs.push_back(idle(4'b0100, 1'b1, 1'b1, 1'b0, 1'b0));
      vecs.push_back(idle(4'b0010, 1'b1, 1'b1, 1'b0, 1'b0));
      vecs.push_back(idle(4'b1001, 1'b1, 1'b1, 1'b0, 1'b0));
      vecs.push_back(idle(4'b1100, 1'b1, 1'b1, 1'b1, 1'b0));
      vecs.push_back(idle(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0));
      // N_pat = 0
      vecs.push_back(v(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 16'd0, 4'b0000, 4'b1100, 1'b0, 1'b0, 1'b1, 1'b0));
      vecs.push_back(idle(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0));
      // MISR, seed 0000, Din 0001
      vecs.push_back(v(1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 16'd2, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0, 4'b0001, 4'b1001, 1'b1, 1'b1, 1'b1, 1'b0));
      vecs.push_back(idle(4'b1001, 1'b0, 1'b0, 1'b0, 1'b0));
      // PRPG lockup from seed 0000
      vecs.push_back(v(1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 16'd3, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0));
      vecs.push_back(idle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b1));
      vecs.push_back(idle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b1));
      vecs.push_back(idle(4'b0000, 1'b1, 1'b1, 1'b1, 1'b1));
      vecs.push_back(idle(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1));
      vecs.push_back(idle(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1));
      vecs.push_back(v(1'b0, 1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0));
      // N_pat=8 run: Poly_ld/Start ignored in RUN, Seed_ld at 2nd Valid aborts
      vecs.push_back(v(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 16'd8, 4'b0000, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0, 16'd0, 4'b0000, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 16'd1, 4'b0000, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0));
      vecs.push_back(v(1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(idle(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(idle(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0));
      // Seed_ld with Start: seed wins, no run
      vecs.push_back(v(1'b0, 1'b1, 4'b0101, 1'b0, 4'b0000, 1'b0, 1'b1, 16'd2, 4'b0000, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(idle(4'b0101, 1'b0, 1'b0, 1'b0, 1'b0));
      // New poly 1001 in IDLE, one step: 0101 -> 1010
      vecs.push_back(v(1'b0, 1'b0, 4'b0000, 1'b1, 4'b1001, 1'b0, 1'b0, 16'd0, 4'b0000, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 16'd1, 4'b0000, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0));
      vecs.push_back(idle(4'b1010, 1'b1, 1'b1, 1'b1, 1'b0));
      vecs.push_back(idle(4'b1010, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs.push_back(v(1'b0, 1'b0, 4'b0000, 1'b1, 4'b0011, 1'b0, 1'b0, 16'd0, 4'b0000, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0));

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i], $sformatf("vec%0d", i));
      end

      // Full period of poly 0011 from seed 1000
      seq15 = '{4'b0100, 4'b0010, 4'b1001, 4'b1100, 4'b0110, 4'b1011, 4'b0101, 4'b1010,
                4'b1101, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b1000};
      apply(v(1'b0, 1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0), "p15_seed");
      apply(v(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 16'd15, 4'b0000, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0), "p15_start");
      for (int i = 0; i < 15; i++) begin
         apply(idle(seq15[i], 1'b1, 1'b1, (i == 14), 1'b0), $sformatf("p15_step%0d", i + 1));
      end
      apply(idle(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0), "p15_end");

      // RST mid-run with Lockup set
      apply(v(1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0), "rst_seed");
      apply(v(1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 16'd8, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0), "rst_start");
      apply(idle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b1), "rst_step1");
      apply(idle(4'b0000, 1'b1, 1'b1, 1'b0, 1'b1), "rst_step2");
      apply(v(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 16'd0, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0), "rst_mid");
      apply(idle(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0), "rst_after");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
